// File: rtl/lights_nios2_qsys_0_oci_dct_packer.sv
// lights_nios2_qsys_0_oci_dct_packer: packs 3-bit trace atoms into 30-bit words and flushes on end request
module lights_nios2_qsys_0_oci_dct_packer #(
  parameter int ATOM_W  = 3,
  parameter int DEPTH   = 10,
  parameter int COUNT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom,
  output logic                      atom_ready,
  input  logic                      end_req,
  output logic [ATOM_W*DEPTH-1:0]   dct_buffer,
  output logic [COUNT_W-1:0]        dct_count,
  output logic                      dct_valid,
  input  logic                      dct_ready,
  output logic                      test_ending,
  output logic                      test_has_ended
);
  localparam int BUF_W = ATOM_W * DEPTH;
  localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);
  logic [BUF_W-1:0] acc_buf_q, acc_buf_d, dct_buffer_q, dct_buffer_d;
  logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d, dct_count_q, dct_count_d;
  logic dct_valid_q, dct_valid_d, flush_q, flush_d, ended_q, ended_d;
  logic test_ending_q, test_ending_d, test_has_ended_q, test_has_ended_d;
  logic accept, xfer, done;
  // ended_q also blocks intake: it rises one edge before test_has_ended
  assign atom_ready = (acc_cnt_q < FULL) && !flush_q && !ended_q && !test_has_ended_q;
  assign accept = atom_valid && atom_ready;
  assign xfer = (acc_cnt_q == FULL || (flush_q && acc_cnt_q != '0)) && (!dct_valid_q || dct_ready);
  assign done = flush_q && acc_cnt_q == '0 && !dct_valid_q;
  always_comb begin
    acc_buf_d = acc_buf_q;
    for (int i = 0; i < DEPTH; i++)
      if (accept && acc_cnt_q == COUNT_W'(i)) acc_buf_d[i*ATOM_W +: ATOM_W] = atom;
    acc_buf_d = xfer ? '0 : acc_buf_d;
    acc_cnt_d = xfer ? '0 : accept ? acc_cnt_q + 1'b1 : acc_cnt_q;
    dct_buffer_d = xfer ? acc_buf_q : dct_buffer_q;
    dct_count_d = xfer ? acc_cnt_q : dct_count_q;
    dct_valid_d = xfer || (dct_valid_q && !dct_ready);
    flush_d = !done && (flush_q || (end_req && !ended_q && !test_has_ended_q));
    ended_d = ended_q || done;
    test_ending_d = done;
    test_has_ended_d = ended_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_buf_q <= '0;
      acc_cnt_q <= '0;
      dct_buffer_q <= '0;
      dct_count_q <= '0;
      dct_valid_q <= 1'b0;
      flush_q <= 1'b0;
      ended_q <= 1'b0;
      test_ending_q <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      acc_buf_q <= acc_buf_d;
      acc_cnt_q <= acc_cnt_d;
      dct_buffer_q <= dct_buffer_d;
      dct_count_q <= dct_count_d;
      dct_valid_q <= dct_valid_d;
      flush_q <= flush_d;
      ended_q <= ended_d;
      test_ending_q <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end
  assign dct_buffer = dct_buffer_q;
  assign dct_count = dct_count_q;
  assign dct_valid = dct_valid_q;
  assign test_ending = test_ending_q;
  assign test_has_ended = test_has_ended_q;
endmodule

// File: tb/tb_lights_nios2_qsys_0_oci_dct_packer.sv
// tb_lights_nios2_qsys_0_oci_dct_packer: directed scenario tests for the trace atom packer
module tb_lights_nios2_qsys_0_oci_dct_packer;
  logic clk, reset_n, atom_valid, atom_ready, end_req, dct_valid, dct_ready, test_ending, test_has_ended;
  logic [2:0] atom;
  logic [29:0] dct_buffer;
  logic [3:0] dct_count;
  int checks = 0, failures = 0, low = 0;
  logic [2:0] pend[$];
  logic [29:0] wbuf[$];
  logic [3:0] wcnt[$];

  lights_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom(atom), .atom_ready(atom_ready),
    .end_req(end_req), .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
    .dct_ready(dct_ready), .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      logic a, h;
      logic [29:0] b;
      logic [3:0] k;
      atom_valid = pend.size() > 0;
      atom = 3'd0;
      if (pend.size() > 0) atom = pend[0];
      a = atom_valid && atom_ready;
      h = dct_valid && dct_ready;
      b = dct_buffer;
      k = dct_count;
      if (atom_valid && !atom_ready) low++;
      @(posedge clk); #1;
      if (a) pend.delete(0);
      if (h) begin wbuf.push_back(b); wcnt.push_back(k); end
    end
    atom_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; atom_valid = 1'b0; atom = 3'd0; end_req = 1'b0; dct_ready = 1'b0;
    pend.delete(); wbuf.delete(); wcnt.delete(); low = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #2;
    checks++; if (dct_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dct_valid); end
    checks++; if (dct_buffer !== 30'd0) begin failures++; $display("FAIL reset_buffer got=%h exp=0", dct_buffer); end
    checks++; if (dct_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dct_count); end
    checks++; if ({test_ending, test_has_ended} !== 2'b00) begin failures++; $display("FAIL reset_end got=%b exp=00", {test_ending, test_has_ended}); end
    apply_reset();
    checks++; if (atom_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", atom_ready); end
  endtask

  task automatic test_full_word();
    apply_reset();
    dct_ready = 1'b1;
    pend = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    step(10);
    checks++; if ({dct_valid, atom_ready} !== 2'b00) begin failures++; $display("FAIL full_k valid/ready got=%b exp=00", {dct_valid, atom_ready}); end
    @(posedge clk); #1;
    checks++; if (dct_valid !== 1'b1) begin failures++; $display("FAIL full_k1_valid got=%b exp=1", dct_valid); end
    checks++; if (dct_buffer !== 30'h08FAC688) begin failures++; $display("FAIL full_buffer got=%h exp=08fac688", dct_buffer); end
    checks++; if (dct_count !== 4'd10) begin failures++; $display("FAIL full_count got=%0d exp=10", dct_count); end
    @(posedge clk); #1;
    checks++; if ({dct_valid, atom_ready} !== 2'b01) begin failures++; $display("FAIL full_k2 valid/ready got=%b exp=01", {dct_valid, atom_ready}); end
    checks++; if (dct_buffer !== 30'h08FAC688) begin failures++; $display("FAIL full_hold got=%h exp=08fac688", dct_buffer); end
  endtask

  task automatic test_stream();
    apply_reset();
    dct_ready = 1'b1;
    for (int i = 0; i < 30; i++) pend.push_back(3'd7);
    step(35);
    checks++; if (pend.size() != 0) begin failures++; $display("FAIL stream_left got=%0d exp=0", pend.size()); end
    checks++; if (low != 2) begin failures++; $display("FAIL stream_ready_low got=%0d exp=2", low); end
    checks++; if (wbuf.size() != 3) begin failures++; $display("FAIL stream_words got=%0d exp=3", wbuf.size()); end
    for (int i = 0; i < wbuf.size(); i++) begin
      checks++; if (wbuf[i] !== 30'h3FFFFFFF || wcnt[i] !== 4'd10) begin failures++; $display("FAIL stream_word%0d got=%h/%0d exp=3fffffff/10", i, wbuf[i], wcnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 25; i++) pend.push_back(3'(i));
    step(25);
    checks++; if (pend.size() != 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=20", 25 - pend.size()); end
    checks++; if ({dct_valid, atom_ready} !== 2'b10) begin failures++; $display("FAIL bp_valid/ready got=%b exp=10", {dct_valid, atom_ready}); end
    checks++; if (dct_buffer !== 30'h08FAC688 || dct_count !== 4'd10) begin failures++; $display("FAIL bp_stable got=%h/%0d exp=08fac688/10", dct_buffer, dct_count); end
    dct_ready = 1'b1;
    step(20);
    checks++; if (wbuf.size() != 2 || pend.size() != 0) begin failures++; $display("FAIL bp_drain words=%0d left=%0d exp=2/0", wbuf.size(), pend.size()); end
    if (wbuf.size() == 2) begin
      checks++; if (wbuf[0] !== 30'h08FAC688 || wcnt[0] !== 4'd10) begin failures++; $display("FAIL bp_word0 got=%h/%0d exp=08fac688/10", wbuf[0], wcnt[0]); end
      checks++; if (wbuf[1] !== 30'h1A23EB1A || wcnt[1] !== 4'd10) begin failures++; $display("FAIL bp_word1 got=%h/%0d exp=1a23eb1a/10", wbuf[1], wcnt[1]); end
    end
    end_req = 1'b1;
    step(1);
    end_req = 1'b0;
    step(5);
    checks++; if (wbuf.size() != 3) begin failures++; $display("FAIL bp_tail_words got=%0d exp=3", wbuf.size()); end
    else begin
      checks++; if (wbuf[2] !== 30'h00000FAC || wcnt[2] !== 4'd5) begin failures++; $display("FAIL bp_tail got=%h/%0d exp=00000fac/5", wbuf[2], wcnt[2]); end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    dct_ready = 1'b1;
    pend = '{3'd5, 3'd2, 3'd7};
    step(3);
    end_req = 1'b1;
    @(posedge clk); #1;
    end_req = 1'b0;
    checks++; if ({dct_valid, atom_ready} !== 2'b00) begin failures++; $display("FAIL flush_set valid/ready got=%b exp=00", {dct_valid, atom_ready}); end
    @(posedge clk); #1;
    checks++; if (dct_valid !== 1'b1 || dct_buffer !== 30'h000001D5 || dct_count !== 4'd3) begin failures++; $display("FAIL flush_word got=%b/%h/%0d exp=1/000001d5/3", dct_valid, dct_buffer, dct_count); end
    @(posedge clk); #1;
    checks++; if ({dct_valid, test_ending} !== 2'b00) begin failures++; $display("FAIL flush_hs valid/ending got=%b exp=00", {dct_valid, test_ending}); end
    @(posedge clk); #1;
    checks++; if ({test_ending, test_has_ended} !== 2'b10) begin failures++; $display("FAIL flush_ending got=%b exp=10", {test_ending, test_has_ended}); end
    pend.push_back(3'd3);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if ({test_ending, test_has_ended, atom_ready, dct_valid} !== 4'b0100) begin failures++; $display("FAIL flush_after%0d ending/ended/ready/valid got=%b exp=0100", i, {test_ending, test_has_ended, atom_ready, dct_valid}); end
    end
    checks++; if (pend.size() != 1) begin failures++; $display("FAIL flush_no_accept left=%0d exp=1", pend.size()); end
  endtask

  task automatic test_empty_flush();
    apply_reset();
    dct_ready = 1'b1;
    end_req = 1'b1;
    @(posedge clk); #1;
    end_req = 1'b0;
    checks++; if ({test_ending, atom_ready} !== 2'b00) begin failures++; $display("FAIL empty_e0 ending/ready got=%b exp=00", {test_ending, atom_ready}); end
    @(posedge clk); #1;
    checks++; if ({test_ending, test_has_ended, dct_valid} !== 3'b100) begin failures++; $display("FAIL empty_e1 ending/ended/valid got=%b exp=100", {test_ending, test_has_ended, dct_valid}); end
    @(posedge clk); #1;
    checks++; if ({test_ending, test_has_ended} !== 2'b01) begin failures++; $display("FAIL empty_e2 ending/ended got=%b exp=01", {test_ending, test_has_ended}); end
    end_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      end_req = 1'b0;
      checks++; if ({test_ending, test_has_ended, dct_valid} !== 3'b010) begin failures++; $display("FAIL empty_again%0d ending/ended/valid got=%b exp=010", i, {test_ending, test_has_ended, dct_valid}); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 16; i++) pend.push_back(3'd6);
    step(20);
    checks++; if (dct_valid !== 1'b1 || pend.size() != 0) begin failures++; $display("FAIL mid_setup valid=%b left=%0d exp=1/0", dct_valid, pend.size()); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({dct_valid, test_ending, test_has_ended} !== 3'b000 || dct_buffer !== 30'd0 || dct_count !== 4'd0) begin failures++; $display("FAIL mid_reset got=%b/%h/%0d exp=000/0/0", {dct_valid, test_ending, test_has_ended}, dct_buffer, dct_count); end
    apply_reset();
    dct_ready = 1'b1;
    for (int i = 0; i < 10; i++) pend.push_back(3'd1);
    step(14);
    checks++; if (wbuf.size() != 1) begin failures++; $display("FAIL mid_words got=%0d exp=1", wbuf.size()); end
    else begin
      checks++; if (wbuf[0] !== 30'h09249249 || wcnt[0] !== 4'd10) begin failures++; $display("FAIL mid_word got=%h/%0d exp=09249249/10", wbuf[0], wcnt[0]); end
    end
  endtask

  initial begin
    reset_n = 1'b0; atom_valid = 1'b0; atom = 3'd0; end_req = 1'b0; dct_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_word();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
